// File: rtl/uart_msg_sender_if.sv
// Avalon-MM register-port bundle between uart_msg_sender (master) and the UART core (slave).
// Signal names keep the master-side _i/_o suffixes so existing connections map one-to-one.
interface uart_msg_sender_if;
   logic [3:0] avm_address_o;
   logic       avm_read_o;
   logic       avm_write_o;
   logic [7:0] avm_writedata_o;
   logic [7:0] avm_readdata_i;

   modport master (
      output avm_address_o,
      output avm_read_o,
      output avm_write_o,
      output avm_writedata_o,
      input  avm_readdata_i
   );

   modport slave (
      input  avm_address_o,
      input  avm_read_o,
      input  avm_write_o,
      input  avm_writedata_o,
      output avm_readdata_i
   );
endinterface

// File: rtl/uart_msg_sender.sv
// Streams a fixed ASCII message into the UART core's TX register, polling the
// status register (addr 1, bit 0) before every write and once more after the last.
module uart_msg_sender #(
   parameter int unsigned          MSG_LEN       = 12,
   parameter logic [8*MSG_LEN-1:0] MSG           = "Hello world!",
   parameter int unsigned          SETTLE_CYCLES = 4,
   parameter int unsigned          TIMEOUT_POLLS = 0
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   uart_msg_sender_if.master avm
);

   localparam int unsigned IW = (MSG_LEN < 1) ? 1 : $clog2(MSG_LEN + 1);
   localparam int unsigned SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
   localparam int unsigned PW = (TIMEOUT_POLLS < 2) ? 1 : $clog2(TIMEOUT_POLLS + 1);

   localparam logic [IW-1:0] MSG_LEN_C = IW'(MSG_LEN);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_POLL_RD  = 3'd1;
   localparam logic [2:0] S_POLL_CHK = 3'd2;
   localparam logic [2:0] S_WRITE    = 3'd3;
   localparam logic [2:0] S_SETTLE   = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;
   localparam logic [2:0] S_ERROR    = 3'd6;

   logic [2:0]    state_q,  state_d;
   logic [IW-1:0] idx_q,    idx_d;
   logic [PW-1:0] poll_q,   poll_d;
   logic [SW-1:0] settle_q, settle_d;

   logic       busy_q,  busy_d;
   logic       done_q,  done_d;
   logic       error_q, error_d;
   logic       read_q,  read_d;
   logic       write_q, write_d;
   logic [3:0] addr_q,  addr_d;
   logic [7:0] wdata_q, wdata_d;

   logic [8*MSG_LEN-1:0] msg_shift;
   logic [7:0]           cur_char;

   // Shift the selected character up to the top byte: index 0 is the MSB byte.
   always_comb begin
      msg_shift = MSG << (8 * idx_q);
      cur_char  = msg_shift[8*MSG_LEN-1 -: 8];
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      poll_d   = poll_q;
      settle_d = settle_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_POLL_RD;
               idx_d   = '0;
               poll_d  = '0;
            end
         end

         S_POLL_RD: state_d = S_POLL_CHK;

         S_POLL_CHK: begin
            if (avm.avm_readdata_i[0]) begin
               poll_d  = '0;
               state_d = (idx_q < MSG_LEN_C) ? S_WRITE : S_DONE;
            end else begin
               if (poll_q != '1) begin
                  poll_d = poll_q + 1'b1;
               end
               if ((TIMEOUT_POLLS != 0) && ((32'(poll_q) + 32'd1) == TIMEOUT_POLLS)) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_POLL_RD;
               end
            end
         end

         S_WRITE: begin
            idx_d    = idx_q + 1'b1;
            settle_d = '0;
            state_d  = S_SETTLE;
         end

         S_SETTLE: begin
            if (32'(settle_q) == (SETTLE_CYCLES - 1)) begin
               state_d = S_POLL_RD;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end

         S_DONE: state_d = S_IDLE;

         S_ERROR: begin
            idx_d   = '0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Bus and status outputs are decoded from the next state and registered,
   // so each strobe lines up exactly with the cycle its state is occupied.
   always_comb begin
      read_d  = (state_d == S_POLL_RD);
      write_d = (state_d == S_WRITE);
      addr_d  = read_d ? 4'd1 : 4'd0;
      wdata_d = write_d ? cur_char : wdata_q;
      done_d  = (state_d == S_DONE);
      error_d = (state_d == S_ERROR);
      busy_d  = (state_d == S_POLL_RD) || (state_d == S_POLL_CHK) ||
                (state_d == S_WRITE)   || (state_d == S_SETTLE);
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         poll_q   <= '0;
         settle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         poll_q   <= poll_d;
         settle_q <= settle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
         read_q   <= read_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign busy_o              = busy_q;
   assign done_o              = done_q;
   assign error_o             = error_q;
   assign avm.avm_read_o      = read_q;
   assign avm.avm_write_o     = write_q;
   assign avm.avm_address_o   = addr_q;
   assign avm.avm_writedata_o = wdata_q;

endmodule

// File: tb/tb_uart_msg_sender.sv
// Directed bench for uart_msg_sender: a UART register-slave model answers polls,
// logs every write, and each scenario task checks its own expectations.
module tb_uart_msg_sender;

   logic clk = 1'b0;
   logic arst = 1'b1;
   logic start = 1'b0;
   logic start2 = 1'b0;
   logic busy, done, error;
   logic busy2, done2, error2;

   uart_msg_sender_if bus ();
   uart_msg_sender_if bus2 ();

   uart_msg_sender dut (
      .clk_i   (clk),
      .arst_i  (arst),
      .start_i (start),
      .busy_o  (busy),
      .done_o  (done),
      .error_o (error),
      .avm     (bus)
   );

   uart_msg_sender #(.TIMEOUT_POLLS(3)) dut_to (
      .clk_i   (clk),
      .arst_i  (arst),
      .start_i (start2),
      .busy_o  (busy2),
      .done_o  (done2),
      .error_o (error2),
      .avm     (bus2)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int st_cyc;

   logic [7:0] exp_msg [12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                                8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

   // Slave-model state; written only by the monitor blocks below.
   int         rcnt = 0, wcnt = 0, done_cnt = 0, err_cnt = 0;
   int         viol = 0, addr_bad = 0, overlap = 0;
   int         nr_left = 0;
   bit         rdy_seen = 1'b0;
   logic [7:0] wdata [256];
   int         wcyc  [256];
   int         bp_n = 0;

   int         rcnt2 = 0, wcnt2 = 0, done_cnt2 = 0, err_cnt2 = 0;
   logic [7:0] wdata2 [64];
   bit         rdy2 = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (arst) rdy_seen = 1'b0;
      if (start) nr_left = bp_n;
      if (bus.avm_read_o && bus.avm_write_o) overlap++;
      if (bus.avm_read_o) begin
         rcnt++;
         if (bus.avm_address_o !== 4'd1) addr_bad++;
         if (nr_left > 0) begin
            bus.avm_readdata_i = 8'h00;
            nr_left--;
         end else begin
            bus.avm_readdata_i = 8'h01;
            rdy_seen = 1'b1;
         end
      end
      if (bus.avm_write_o) begin
         if (wcnt < 256) begin
            wdata[wcnt] = bus.avm_writedata_o;
            wcyc[wcnt]  = cyc;
         end
         wcnt++;
         if (bus.avm_address_o !== 4'd0) addr_bad++;
         if (!rdy_seen) viol++;
         rdy_seen = 1'b0;
         nr_left  = bp_n;
      end
      if (done)  done_cnt++;
      if (error) err_cnt++;
   end

   always @(negedge clk) begin
      if (bus2.avm_read_o) begin
         rcnt2++;
         bus2.avm_readdata_i = {7'b0, rdy2};
      end
      if (bus2.avm_write_o) begin
         if (wcnt2 < 64) wdata2[wcnt2] = bus2.avm_writedata_o;
         wcnt2++;
      end
      if (done2)  done_cnt2++;
      if (error2) err_cnt2++;
   end

   task automatic pulse_start(input bit second);
      @(negedge clk);
      if (second) start2 = 1'b1; else start = 1'b1;
      st_cyc = cyc;
      @(negedge clk);
      start  = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk); #1;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_writes(input int target, input int limit, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk); #1;
         if (wcnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({busy, done, error, bus.avm_read_o, bus.avm_write_o, bus.avm_address_o,
           bus.avm_writedata_o} !== 17'h0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0", {busy, done, error, bus.avm_read_o,
                  bus.avm_write_o, bus.avm_address_o, bus.avm_writedata_o});
      end
      total++;
      if ({busy2, done2, error2, bus2.avm_read_o, bus2.avm_write_o} !== 5'h0) begin
         bad++;
         $display("FAIL reset_outputs_to: got %b want 0",
                  {busy2, done2, error2, bus2.avm_read_o, bus2.avm_write_o});
      end
      @(negedge clk);
      arst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_happy;
      int  wb, rb, db, blow;
      bit  ok;
      wb = wcnt; rb = rcnt; db = done_cnt; blow = 0; ok = 1'b0;
      bp_n = 0;
      pulse_start(1'b0);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk); #1;
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (!busy) blow++;
      end
      total++;
      if (!ok) begin bad++; $display("FAIL happy_done_timeout: done_o not seen in 400 cycles"); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL happy_busy_at_done: got %b want 0", busy); end
      total++;
      if (blow != 0) begin bad++; $display("FAIL happy_busy_gap: got %0d low cycles want 0", blow); end
      repeat (6) @(negedge clk);
      #1;
      total++;
      if (wcnt - wb != 12) begin bad++; $display("FAIL happy_writes: got %0d want 12", wcnt - wb); end
      total++;
      if (rcnt - rb != 13) begin bad++; $display("FAIL happy_reads: got %0d want 13", rcnt - rb); end
      total++;
      if (done_cnt - db != 1) begin bad++; $display("FAIL happy_done_count: got %0d want 1", done_cnt - db); end
      for (int i = 0; i < 12; i++) begin
         total++;
         if (wdata[wb + i] !== exp_msg[i]) begin
            bad++;
            $display("FAIL happy_data[%0d]: got %h want %h", i, wdata[wb + i], exp_msg[i]);
         end
      end
      total++;
      if (wcyc[wb] - st_cyc != 3) begin
         bad++;
         $display("FAIL happy_first_write_latency: got %0d want 3", wcyc[wb] - st_cyc);
      end
      for (int i = 1; i < 12; i++) begin
         total++;
         if (wcyc[wb + i] - wcyc[wb + i - 1] != 7) begin
            bad++;
            $display("FAIL happy_spacing[%0d]: got %0d want 7", i, wcyc[wb + i] - wcyc[wb + i - 1]);
         end
      end
      total++;
      if (bus.avm_writedata_o !== 8'h21) begin
         bad++;
         $display("FAIL happy_writedata_hold: got %h want 21", bus.avm_writedata_o);
      end
      total++;
      if (bus.avm_address_o !== 4'd0) begin
         bad++;
         $display("FAIL happy_idle_address: got %h want 0", bus.avm_address_o);
      end
   endtask

   task automatic test_backpressure;
      int  wb, rb;
      bit  ok;
      wb = wcnt; rb = rcnt;
      bp_n = 5;
      pulse_start(1'b0);
      wait_done(1000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL bp_done_timeout: done_o not seen in 1000 cycles"); end
      repeat (4) @(negedge clk);
      #1;
      total++;
      if (wcnt - wb != 12) begin bad++; $display("FAIL bp_writes: got %0d want 12", wcnt - wb); end
      total++;
      if (rcnt - rb != 78) begin bad++; $display("FAIL bp_reads: got %0d want 78", rcnt - rb); end
      for (int i = 0; i < 12; i++) begin
         total++;
         if (wdata[wb + i] !== exp_msg[i]) begin
            bad++;
            $display("FAIL bp_data[%0d]: got %h want %h", i, wdata[wb + i], exp_msg[i]);
         end
      end
      bp_n = 0;
   endtask

   task automatic test_timeout;
      int  rb, wb, db, eb;
      bit  ok;
      rb = rcnt2; wb = wcnt2; db = done_cnt2; eb = err_cnt2; ok = 1'b0;
      rdy2 = 1'b0;
      pulse_start(1'b1);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk); #1;
         if (error2) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin bad++; $display("FAIL to_error_timeout: error_o not seen in 100 cycles"); end
      total++;
      if (busy2 !== 1'b0) begin bad++; $display("FAIL to_busy_at_error: got %b want 0", busy2); end
      repeat (5) @(negedge clk);
      #1;
      total++;
      if (rcnt2 - rb != 3) begin bad++; $display("FAIL to_reads: got %0d want 3", rcnt2 - rb); end
      total++;
      if (wcnt2 - wb != 0) begin bad++; $display("FAIL to_writes: got %0d want 0", wcnt2 - wb); end
      total++;
      if (err_cnt2 - eb != 1) begin bad++; $display("FAIL to_error_count: got %0d want 1", err_cnt2 - eb); end
      total++;
      if (done_cnt2 - db != 0) begin bad++; $display("FAIL to_done_count: got %0d want 0", done_cnt2 - db); end

      wb = wcnt2; db = done_cnt2; ok = 1'b0;
      rdy2 = 1'b1;
      pulse_start(1'b1);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk); #1;
         if (done2) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin bad++; $display("FAIL to_retry_done_timeout: done_o not seen in 400 cycles"); end
      @(negedge clk); #1;
      total++;
      if (wcnt2 - wb != 12) begin bad++; $display("FAIL to_retry_writes: got %0d want 12", wcnt2 - wb); end
      total++;
      if (wdata2[wb] !== 8'h48) begin bad++; $display("FAIL to_retry_first: got %h want 48", wdata2[wb]); end
      total++;
      if (wdata2[wb + 11] !== 8'h21) begin bad++; $display("FAIL to_retry_last: got %h want 21", wdata2[wb + 11]); end
   endtask

   task automatic test_start_busy;
      int  wb, rb, db;
      bit  ok;
      wb = wcnt; rb = rcnt; db = done_cnt;
      pulse_start(1'b0);
      wait_writes(wb + 3, 200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL sb_mid_timeout: 3 writes not seen in 200 cycles"); end
      pulse_start(1'b0);
      wait_done(400, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL sb_done_timeout: done_o not seen in 400 cycles"); end
      repeat (20) @(negedge clk);
      #1;
      total++;
      if (wcnt - wb != 12) begin bad++; $display("FAIL sb_writes: got %0d want 12", wcnt - wb); end
      total++;
      if (rcnt - rb != 13) begin bad++; $display("FAIL sb_reads: got %0d want 13", rcnt - rb); end
      total++;
      if (done_cnt - db != 1) begin bad++; $display("FAIL sb_done_count: got %0d want 1", done_cnt - db); end
      total++;
      if (wdata[wb + 3] !== exp_msg[3]) begin
         bad++;
         $display("FAIL sb_data3: got %h want %h", wdata[wb + 3], exp_msg[3]);
      end
   endtask

   task automatic test_reset_mid;
      int  wb, rb, db;
      bit  ok;
      wb = wcnt;
      pulse_start(1'b0);
      wait_writes(wb + 5, 200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rm_mid_timeout: 5 writes not seen in 200 cycles"); end
      @(negedge clk);
      arst = 1'b1;
      #1;
      total++;
      if ({busy, done, error, bus.avm_read_o, bus.avm_write_o, bus.avm_address_o,
           bus.avm_writedata_o} !== 17'h0) begin
         bad++;
         $display("FAIL rm_outputs_in_reset: got %h want 0", {busy, done, error, bus.avm_read_o,
                  bus.avm_write_o, bus.avm_address_o, bus.avm_writedata_o});
      end
      wb = wcnt; rb = rcnt;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ((wcnt - wb) + (rcnt - rb) != 0) begin
         bad++;
         $display("FAIL rm_strobes_in_reset: got %0d want 0", (wcnt - wb) + (rcnt - rb));
      end
      arst = 1'b0;
      wb = wcnt; db = done_cnt;
      pulse_start(1'b0);
      wait_done(400, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rm_done_timeout: done_o not seen in 400 cycles"); end
      @(negedge clk); #1;
      total++;
      if (wdata[wb] !== 8'h48) begin bad++; $display("FAIL rm_restart_first: got %h want 48", wdata[wb]); end
      total++;
      if (wcnt - wb != 12) begin bad++; $display("FAIL rm_restart_writes: got %0d want 12", wcnt - wb); end
      total++;
      if (done_cnt - db != 1) begin bad++; $display("FAIL rm_done_count: got %0d want 1", done_cnt - db); end
   endtask

   initial begin
      test_reset;
      test_happy;
      test_backpressure;
      test_timeout;
      test_start_busy;
      test_reset_mid;
      #1;
      total++;
      if (viol != 0) begin bad++; $display("FAIL write_without_ready: got %0d want 0", viol); end
      total++;
      if (addr_bad != 0) begin bad++; $display("FAIL strobe_address: got %0d want 0", addr_bad); end
      total++;
      if (overlap != 0) begin bad++; $display("FAIL read_write_overlap: got %0d want 0", overlap); end
      total++;
      if (err_cnt != 0) begin bad++; $display("FAIL default_error_count: got %0d want 0", err_cnt); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
